// File: rtl/multiplexed_display_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// multiplexed_display_driver
//
// Time-multiplexed driver for common-anode seven-segment displays. One digit is
// scanned per slot of 2^SCAN_DIV clocks. Each slot starts with one dead-time
// cycle to stop ghosting. Within a slot the digit is PWM-dimmed by the
// brightness setting. Digits can blink individually, and leading zeros can be
// blanked. All user inputs are captured into shadow registers at slot
// boundaries, so a slot never mixes old and new input values.
//
// Parameters:
//   DIGITS    number of digits (1..16)
//   SCAN_DIV  log2 of the slot length in clocks (must exceed PWM_BITS)
//   PWM_BITS  width of the brightness control
//   BLINK_DIV blink phase toggles every 2^(BLINK_DIV-1) clocks
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   data           4*DIGITS  nibble k = data[4k+3:4k] drives digit k
//   pointEnable    DIGITS    decimal point on for digit k
//   blinkMask      DIGITS    digit k blanks during the blink-off phase
//   brightness     PWM_BITS  duty = (brightness+1)/2^PWM_BITS
//   suppressZeros  1         enables leading-zero blanking
//   segmentEnableN 8         active-low segments, bit0..6 = a..g, bit7 = dp
//   digitEnableN   DIGITS    active-low digit strobes, at most one low
//   scanIndex      IW        digit currently being scanned
// -----------------------------------------------------------------------------
module multiplexed_display_driver #(
    parameter  int DIGITS    = 4,
    parameter  int SCAN_DIV  = 16,
    parameter  int PWM_BITS  = 4,
    parameter  int BLINK_DIV = 24,
    localparam int IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     pointEnable,
    input  logic [DIGITS-1:0]     blinkMask,
    input  logic [PWM_BITS-1:0]   brightness,
    input  logic                  suppressZeros,
    output logic [7:0]            segmentEnableN,
    output logic [DIGITS-1:0]     digitEnableN,
    output logic [IW-1:0]         scanIndex
);

    localparam logic [SCAN_DIV-1:0] PRESCALE_MAX = '1;
    localparam logic [IW-1:0]       LAST_DIGIT   = IW'(DIGITS - 1);

    // Active-low hex font for segments a..g (bit0 = a).
    function automatic logic [6:0] hexFont(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    // Scan, blink and shadow state.
    logic [SCAN_DIV-1:0]  prescaler;
    logic [BLINK_DIV-1:0] blinkCount;
    logic [4*DIGITS-1:0]  dataShadow;
    logic [DIGITS-1:0]    pointShadow;
    logic [DIGITS-1:0]    blinkShadow;
    logic [PWM_BITS-1:0]  brightnessShadow;
    logic                 suppressShadow;

    logic slotWrap;
    logic captureNow;

    assign slotWrap   = (prescaler == PRESCALE_MAX);
    // Capturing on prescaler==0 as well as on the wrap makes the values
    // present right after reset visible from the first lit cycle, instead
    // of waiting a whole slot with all-zero shadows.
    assign captureNow = slotWrap || (prescaler == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler        <= '0;
            blinkCount       <= '0;
            scanIndex        <= '0;
            dataShadow       <= '0;
            pointShadow      <= '0;
            blinkShadow      <= '0;
            brightnessShadow <= '0;
            suppressShadow   <= 1'b0;
        end else begin
            prescaler  <= prescaler + 1'b1;
            blinkCount <= blinkCount + 1'b1;
            if (slotWrap) begin
                scanIndex <= (scanIndex == LAST_DIGIT) ? '0 : scanIndex + 1'b1;
            end
            if (captureNow) begin
                dataShadow       <= data;
                pointShadow      <= pointEnable;
                blinkShadow      <= blinkMask;
                brightnessShadow <= brightness;
                suppressShadow   <= suppressZeros;
            end
        end
    end

    // ---- stage p0: decode of the current state (combinational) ----

    // Leading-zero blanking, walking down from the most significant digit.
    // A digit with its decimal point set counts as significant. Digit 0 is
    // never blanked so that a zero value still shows "0".
    logic [DIGITS-1:0] suppressedP0;

    always_comb begin : leadingZeros
        logic stillLeading;
        suppressedP0 = '0;
        stillLeading = suppressShadow;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (stillLeading && (dataShadow[4*k +: 4] == 4'h0) && !pointShadow[k]) begin
                suppressedP0[k] = 1'b1;
            end else begin
                stillLeading = 1'b0;
            end
        end
    end

    // Per-digit attributes of the digit being scanned.
    logic [3:0] nibbleP0;
    logic       pointP0;
    logic       blinkP0;
    logic       suppressP0;

    always_comb begin
        nibbleP0   = 4'h0;
        pointP0    = 1'b0;
        blinkP0    = 1'b0;
        suppressP0 = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (scanIndex == IW'(k)) begin
                nibbleP0   = dataShadow[4*k +: 4];
                pointP0    = pointShadow[k];
                blinkP0    = blinkShadow[k];
                suppressP0 = suppressedP0[k];
            end
        end
    end

    // PWM phase is the top PWM_BITS of the prescaler, so each brightness
    // step adds 2^(SCAN_DIV-PWM_BITS) lit clocks per slot.
    logic [PWM_BITS-1:0] phaseP0;
    logic                blinkOffP0;
    logic                litP0;

    assign phaseP0    = prescaler[SCAN_DIV-1 -: PWM_BITS];
    assign blinkOffP0 = blinkCount[BLINK_DIV-1];
    assign litP0      = (prescaler != '0)
                     && (phaseP0 <= brightnessShadow)
                     && !(blinkOffP0 && blinkP0)
                     && !suppressP0;

    logic [7:0]        segmentP0;
    logic [DIGITS-1:0] digitP0;

    always_comb begin
        segmentP0 = litP0 ? {~pointP0, hexFont(nibbleP0)} : 8'hFF;
        for (int k = 0; k < DIGITS; k++) begin
            digitP0[k] = !(litP0 && (scanIndex == IW'(k)));
        end
    end

    // ---- stage p1: registered pin drivers ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            segmentEnableN <= 8'hFF;
            digitEnableN   <= '1;
        end else begin
            segmentEnableN <= segmentP0;
            digitEnableN   <= digitP0;
        end
    end

endmodule

// File: tb/tb_multiplexed_display_driver.sv
`timescale 1ns/1ps
// Bench for multiplexed_display_driver with DIGITS=4, SCAN_DIV=4, PWM_BITS=2,
// BLINK_DIV=8. A cycle-count reference model pushes the expected pin values
// for every clock into a scoreboard queue; they are popped and compared one
// time unit after the edge. Directed checks on top pin down specific values.
module tb_multiplexed_display_driver;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int PWM_BITS  = 2;
    localparam int BLINK_DIV = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  pointEnable = 4'h0;
    logic [3:0]  blinkMask = 4'h0;
    logic [1:0]  brightness = 2'd0;
    logic        suppressZeros = 1'b0;
    logic [7:0]  segmentEnableN;
    logic [3:0]  digitEnableN;
    logic [1:0]  scanIndex;

    multiplexed_display_driver #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .PWM_BITS  (PWM_BITS),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .data           (data),
        .pointEnable    (pointEnable),
        .blinkMask      (blinkMask),
        .brightness     (brightness),
        .suppressZeros  (suppressZeros),
        .segmentEnableN (segmentEnableN),
        .digitEnableN   (digitEnableN),
        .scanIndex      (scanIndex)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] dig;
        logic [1:0] idx;
    } exp_t;

    logic [6:0] fontTbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks   = 0;
    int failures = 0;
    int t        = 0;     // clock edges since reset release
    exp_t sb[$];

    // Reference copy of what the design should have captured.
    logic [15:0] shData;
    logic [3:0]  shPe;
    logic [3:0]  shBm;
    logic [1:0]  shBr;
    logic        shSz;

    int         litCount [4];
    logic [7:0] segAt    [4];

    function automatic exp_t modelOut(int tt);
        exp_t e;
        int p, k;
        bit blinkOff, lit, run;
        bit [3:0] supp;
        logic [3:0] nib;
        p = tt % 16;
        k = (tt / 16) % 4;
        blinkOff = (tt % 256) >= 128;
        supp = '0;
        run = shSz;
        for (int j = 3; j >= 1; j--) begin
            if (run && shData[4*j +: 4] == 4'h0 && !shPe[j]) supp[j] = 1'b1;
            else run = 1'b0;
        end
        nib = shData[4*k +: 4];
        lit = (p != 0) && ((p / 4) <= int'(shBr)) && !(blinkOff && shBm[k]) && !supp[k];
        e.seg = lit ? {~shPe[k], fontTbl[nib]} : 8'hFF;
        e.dig = lit ? ~(4'b0001 << k) : 4'hF;
        e.idx = 2'(((tt + 1) / 16) % 4);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, expv, t);
        end
    endtask

    task automatic clearStats();
        for (int k = 0; k < 4; k++) begin
            litCount[k] = 0;
            segAt[k] = 8'hFF;
        end
    endtask

    // One clock: push expectation, clock, update model, pop and compare.
    task automatic step();
        exp_t e;
        exp_t g;
        int tp;
        sb.push_back(modelOut(t));
        @(posedge clock);
        if ((t % 16) == 0 || (t % 16) == 15) begin
            shData = data;
            shPe   = pointEnable;
            shBm   = blinkMask;
            shBr   = brightness;
            shSz   = suppressZeros;
        end
        t++;
        #1;
        g.seg = segmentEnableN;
        g.dig = digitEnableN;
        g.idx = scanIndex;
        e = sb.pop_front();
        check("scoreboard", 32'(g), 32'(e));
        tp = t - 1;
        for (int k = 0; k < 4; k++) if (digitEnableN[k] === 1'b0) litCount[k]++;
        if ((tp % 16) == 8) segAt[(tp / 16) % 4] = segmentEnableN;
    endtask

    task automatic alignTo(input int modulus, input int value);
        while ((t % modulus) != value) step();
    endtask

    // Called just after a posedge; asserts reset mid-cycle, releases it after
    // the next edge.
    task automatic doReset();
        #2 reset = 1'b1;
        #1;
        check("reset seg", 32'(segmentEnableN), 32'h0FF);
        check("reset dig", 32'(digitEnableN), 32'hF);
        check("reset idx", 32'(scanIndex), 32'h0);
        @(posedge clock);
        #1;
        check("reset held seg", 32'(segmentEnableN), 32'h0FF);
        reset = 1'b0;
        t = 0;
        shData = '0; shPe = '0; shBm = '0; shBr = '0; shSz = 1'b0;
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and basic scan.
        data = 16'h1234; brightness = 2'd3;
        doReset();
        step();
        check("first cycle dark", 32'(segmentEnableN), 32'h0FF);
        step();
        check("first lit dig", 32'(digitEnableN), 32'hE);
        check("first lit seg", 32'(segmentEnableN), 32'h099);
        repeat (78) step();

        // Font and point sweep on digit 0.
        pointEnable = 4'b0001;
        for (int v = 0; v < 16; v++) begin
            data = 16'(v);
            repeat (64) step();
            alignTo(64, 9);
            check("font", 32'(segmentEnableN), 32'({1'b0, fontTbl[v]}));
        end

        // PWM duty inside one digit-0 slot.
        pointEnable = 4'b0000; data = 16'h1234;
        brightness = 2'd0;
        repeat (64) step();
        alignTo(64, 0); clearStats(); repeat (16) step();
        check("pwm0 lit", 32'(litCount[0]), 32'd3);
        brightness = 2'd2;
        repeat (64) step();
        alignTo(64, 0); clearStats(); repeat (16) step();
        check("pwm2 lit", 32'(litCount[0]), 32'd11);

        // Blink on digit 2 over two blink periods.
        brightness = 2'd3; blinkMask = 4'b0100;
        repeat (64) step();
        alignTo(256, 0); clearStats(); repeat (512) step();
        check("blink d2 lit", 32'(litCount[2]), 32'd60);
        check("blink d1 lit", 32'(litCount[1]), 32'd120);
        check("blink d3 lit", 32'(litCount[3]), 32'd120);

        // Leading-zero suppression.
        blinkMask = 4'b0000; suppressZeros = 1'b1; data = 16'h0070;
        repeat (64) step();
        alignTo(64, 0); clearStats(); repeat (64) step();
        check("lz d3 lit", 32'(litCount[3]), 32'd0);
        check("lz d2 lit", 32'(litCount[2]), 32'd0);
        check("lz d1 seg", 32'(segAt[1]), 32'h0F8);
        check("lz d0 seg", 32'(segAt[0]), 32'h0C0);
        data = 16'h0000;
        repeat (64) step();
        alignTo(64, 0); clearStats(); repeat (64) step();
        check("lz zero d1 lit", 32'(litCount[1]), 32'd0);
        check("lz zero d0 lit", 32'(litCount[0]), 32'd15);
        check("lz zero d0 seg", 32'(segAt[0]), 32'h0C0);
        data = 16'h0070; pointEnable = 4'b0100;
        repeat (64) step();
        alignTo(64, 0); clearStats(); repeat (64) step();
        check("lz dp d2 seg", 32'(segAt[2]), 32'h040);
        check("lz dp d3 lit", 32'(litCount[3]), 32'd0);
        check("lz dp d1 seg", 32'(segAt[1]), 32'h0F8);

        // Mid-slot data change holds until the next slot.
        suppressZeros = 1'b0; pointEnable = 4'b0000; data = 16'h1234;
        repeat (64) step();
        alignTo(64, 5);
        data = 16'h5678;
        alignTo(64, 12);
        check("midslot seg", 32'(segmentEnableN), 32'h099);
        check("midslot dig", 32'(digitEnableN), 32'hE);
        alignTo(64, 25);
        check("next slot seg", 32'(segmentEnableN), 32'h0F8);
        check("next slot dig", 32'(digitEnableN), 32'hD);

        // Reset asserted mid-slot.
        alignTo(64, 23);
        doReset();
        step();
        check("post reset dark", 32'(segmentEnableN), 32'h0FF);
        step();
        check("post reset dig", 32'(digitEnableN), 32'hE);
        check("post reset seg", 32'(segmentEnableN), 32'h080);
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiplexed_display_driver.md
# multiplexed_display_driver

Parametrised, time-multiplexed driver for common-anode seven-segment displays with DIGITS digits. It scans one digit at a time, decodes a 4-bit hex nibble per digit, drives per-digit decimal points, and adds PWM brightness control, per-digit blinking, leading-zero suppression and one-cycle anti-ghosting dead time. It sits between user-input logic (data, point and blink masks) and the board's active-low segment and digit pins.

## Interface
- DIGITS, 4, number of digits, 1..16
- SCAN_DIV, 16, each digit slot lasts 2^SCAN_DIV clocks; must exceed PWM_BITS
- PWM_BITS, 4, width of the brightness control
- BLINK_DIV, 24, blink phase toggles every 2^(BLINK_DIV-1) clocks
- IW = max(1, clog2(DIGITS)) (localparam)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clock
- data  in  4*DIGITS  nibble k = data[4k+3:4k] drives digit k (digit 0 = least significant)
- pointEnable  in  DIGITS  decimal point on for digit k
- blinkMask  in  DIGITS  digit k blanks during the blink-off phase
- brightness  in  PWM_BITS  duty = (brightness+1)/2^PWM_BITS
- suppressZeros  in  1  enables leading-zero blanking
- segmentEnableN  out  8  active-low; bit0..6 = a..g, bit7 = dp
- digitEnableN  out  DIGITS  active-low, one-cold
- scanIndex  out  IW  digit currently being scanned

## Operation
- Prescaler: free-running SCAN_DIV-bit counter, wraps 2^SCAN_DIV-1 -> 0.
- scanIndex: advances on the edge where the prescaler wraps; DIGITS-1 -> 0. For DIGITS=1 it stays 0.
- Shadow registers: on the same edge (and whenever prescaler==0 after reset), data, pointEnable, blinkMask, brightness and suppressZeros are captured. All decoding uses shadow values only, so input changes never tear within a slot.
- Blink counter: free-running BLINK_DIV bits. blinkOff = its MSB.
- Leading-zero suppression (suppressZeros=1): scanning from digit DIGITS-1 downward, a digit is suppressed while its nibble is 0 and its pointEnable is 0. The first digit failing either test ends suppression. Digit 0 is never suppressed.
- Digit k is lit iff all of the following hold: prescaler != 0 (dead time), phase <= brightness (phase = prescaler[SCAN_DIV-1 -: PWM_BITS]), not (blinkOff and blinkMask[k]), and not suppressed.
- When lit: digitEnableN = ~(1<<k), segmentEnableN[6:0] = hex font, segmentEnableN[7] = ~pointEnable[k]. When not lit, both outputs are all ones.
- Active-low hex font [6:0]: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.

## Timing
- Outputs are registered: the output in cycle t+1 is f(state at cycle t). Total latency is one clock.
- Reset (async assert, sync-clean deassert): prescaler, scanIndex, blink counter and all shadow registers = 0. segmentEnableN = 8'hFF, digitEnableN = all ones.
- First lit output appears in cycle 2 after reset release (state prescaler=1).
- Each slot produces exactly one dead-time output cycle. The digit is never lit in two slots at once, and at most one digitEnableN bit is low in any cycle.
- brightness = 2^PWM_BITS-1 gives full on, except for the dead-time cycle. brightness = 0 gives 1/2^PWM_BITS duty.
- Input changes take effect at the next slot boundary, plus one cycle.
- If reset is asserted mid-slot, outputs go to all-off immediately (asynchronously), and scanning restarts at digit 0.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=4, PWM_BITS=2, BLINK_DIV=8.
- Reset/scan: release reset with data=16'h1234, brightness=3, others 0. Required: outputs stay FF/F until cycle 2. Then digit 0 shows 19 (hex "4") for 15 cycles, followed by 1 dead cycle, then digit 1 shows 30, digit 2 shows 24, digit 3 shows 79, then the scan wraps to digit 0.
- Font/point sweep: step all 16 nibble values through digit 0 with pointEnable=4'b0001. Required: segmentEnableN matches the font table with bit7=0 in every case.
- PWM: brightness=0 -> digit lit only for phase 0 (3 of 16 cycles, prescaler 1..3). brightness=2 -> lit for prescaler 1..11.
- Blink: blinkMask=4'b0100. Required: digit 2 is dark whenever blink MSB=1 (128-cycle phases), and the other digits are unaffected.
- Zero suppression: data=16'h0070 with suppressZeros=1 -> digits 3 and 2 dark, digit 1 = 78, digit 0 = 40. data=0 -> only digit 0 lit (40). Setting pointEnable[2] with data=16'h0070 -> digit 2 lit as 40 with dp low.
- Mid-slot changes: changing data mid-slot leaves the current slot unchanged. Asserting reset mid-slot gives all-off the same cycle and scanIndex=0; after release, digit 0 is lit at cycle 2.
